// File: rtl/nibble_counter.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_counter
//  Description : Up/down binary counter with enable, parallel load,
//                synchronous clear, programmable terminal value, registered
//                terminal-count pulse and a sticky wrap flag.
//                Optional saturation mode is compiled in when the macro
//                NIBBLE_COUNTER_SAT_EN is defined (adds input 'sat').
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_counter #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    input  logic [WIDTH-1:0] max_val,
`ifdef NIBBLE_COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q,    tc_d;
    logic             wrapped_q, wrapped_d;
    logic             w_sat;

`ifdef NIBBLE_COUNTER_SAT_EN
    assign w_sat = sat;
`else
    assign w_sat = 1'b0;
`endif

    // Next-state selection: clear beats load beats counting beats hold.
    // An up-step from anything at or above the terminal value (possible
    // after loading a value beyond it) is treated as reaching the limit.
    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        wrapped_d = wrapped_q;
        if (clr) begin
            count_d = c_zero;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (up) begin
                if (count_q >= max_val) begin
                    tc_d = 1'b1;
                    if (w_sat) begin
                        count_d = max_val;
                    end else begin
                        count_d   = c_zero;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + c_one;
                end
            end else begin
                if (count_q == c_zero) begin
                    tc_d = 1'b1;
                    if (w_sat) begin
                        count_d = c_zero;
                    end else begin
                        count_d   = max_val;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    count_d = count_q - c_one;
                end
            end
        end
    end

    // State registers; reset acts immediately without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= RST_VAL;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign wrapped = wrapped_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_counter
//  Description : Self-checking bench for nibble_counter; directed scenarios
//                followed by random stimulus against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_counter;

    localparam int c_width = 4;
    localparam int c_mod   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               en, up, load, clr;
    logic [c_width-1:0] load_val, max_val;
    logic               sat;
    logic [c_width-1:0] count;
    logic               tc, wrapped;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_count;
    int m_tc;
    int m_wrapped;

    always #5 clk = ~clk;

    nibble_counter #(.WIDTH(c_width), .RST_VAL(4'd0)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .clr      (clr),
        .max_val  (max_val),
`ifdef NIBBLE_COUNTER_SAT_EN
        .sat      (sat),
`endif
        .count    (count),
        .tc       (tc),
        .wrapped  (wrapped)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},   int'(count),   m_count);
        check({tag, ".tc"},      int'(tc),      m_tc);
        check({tag, ".wrapped"}, int'(wrapped), m_wrapped);
    endtask

    function automatic bit sat_active();
`ifdef NIBBLE_COUNTER_SAT_EN
        return sat;
`else
        return 1'b0;
`endif
    endfunction

    // Behaviour of one rising edge, straight from the counter rules.
    task automatic model_edge();
        int mx;
        mx = int'(max_val);
        if (!rst) begin
            m_count = 0; m_tc = 0; m_wrapped = 0;
        end else if (clr) begin
            m_count = 0; m_tc = 0;
        end else if (load) begin
            m_count = int'(load_val); m_tc = 0;
        end else if (!en) begin
            m_tc = 0;
        end else if (up) begin
            if (m_count >= mx) begin
                m_tc = 1;
                if (sat_active()) m_count = mx;
                else begin m_count = 0; m_wrapped = 1; end
            end else begin
                m_count = (m_count + 1) % c_mod; m_tc = 0;
            end
        end else begin
            if (m_count == 0) begin
                m_tc = 1;
                if (sat_active()) m_count = 0;
                else begin m_count = mx; m_wrapped = 1; end
            end else begin
                m_count = m_count - 1; m_tc = 0;
            end
        end
    endtask

    // One clock: edge, model update, sample 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic i_en, input logic i_up, input logic i_load,
                         input logic [c_width-1:0] i_lv, input logic i_clr,
                         input logic [c_width-1:0] i_max);
        en = i_en; up = i_up; load = i_load; load_val = i_lv; clr = i_clr; max_val = i_max;
    endtask

    initial begin
        int seen_wrap_up;
        rst = 1'b0; sat = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd15);
        m_count = 0; m_tc = 0; m_wrapped = 0;
        #1;
        check_all("reset_async");
        step("reset_hold");
        step("reset_hold");

        // free run 0..15,0..
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd15);
        for (int i = 0; i < 20; i++) begin
            step("freerun");
            check("freerun.const", int'(count), (i + 1) % 16);
        end
        check("freerun.wrapped", int'(wrapped), 1);

        // continue to 9 then assert reset between edges
        for (int i = 0; i < 5; i++) step("to9");
        check("at9", int'(count), 9);
        #2;
        rst = 1'b0;
        m_count = 0; m_tc = 0; m_wrapped = 0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // down with terminal 5 from 0
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5);
        for (int i = 0; i < 7; i++) step("down5");
        check("down5.const", int'(count), 5);

        // priority
        drive(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 4'd15);
        step("prio.clr");
        check("prio.clr0", int'(count), 0);
        clr = 1'b0;
        step("prio.load");
        check("prio.load7", int'(count), 7);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) step("prio.hold");
        check("prio.hold7", int'(count), 7);

        // load above terminal then count up -> wrap
        drive(1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 4'd3);
        step("ldmax.load");
        check("ldmax.12", int'(count), 12);
        load = 1'b0; en = 1'b1;
        step("ldmax.up");
        check("ldmax.0", int'(count), 0);
        check("ldmax.tc", int'(tc), 1);

        // terminal value 0: stays at 0 with tc every enabled cycle
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step("max0.up");
        up = 1'b0;
        for (int i = 0; i < 3; i++) step("max0.dn");

`ifdef NIBBLE_COUNTER_SAT_EN
        // saturation: restart from a fresh reset so wrapped is 0
        @(negedge clk);
        rst = 1'b0; m_count = 0; m_tc = 0; m_wrapped = 0;
        #1; check_all("sat.rst");
        @(negedge clk); rst = 1'b1;
        sat = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 4'd10);
        step("sat.load");
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) step("sat.up");
        check("sat.10", int'(count), 10);
        check("sat.nowrap", int'(wrapped), 0);
        up = 1'b0;
        for (int i = 0; i < 13; i++) step("sat.dn");
        check("sat.0", int'(count), 0);
        sat = 1'b0;
`endif

        // random phase
        seen_wrap_up = 0;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            clr  = (r < 3);
            load = ($urandom_range(0, 99) < 6);
            load_val = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 99) < 80);
            up   = ($urandom_range(0, 99) < 60);
            max_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : max_val;
`ifdef NIBBLE_COUNTER_SAT_EN
            sat  = ($urandom_range(0, 99) < 20);
`endif
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0; m_count = 0; m_tc = 0; m_wrapped = 0;
                #1; check_all("rnd.rst");
                rst = 1'b1;
            end
            step("rnd");
            if (m_tc == 1) seen_wrap_up++;
        end
        check("rnd.tc_seen", int'(seen_wrap_up > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_counter.md
Name: nibble_counter

Overview:
- Synchronous binary up/down counter, default 4 bits, free-running after reset.
- Basic mode (en=1, up=1, load=0, clr=0): count increments by one every rising clk edge and wraps 15->0.
- Adds enable, direction, parallel load, synchronous clear, programmable terminal value, terminal-count pulse and sticky wrap flag.
- Sits as a leaf timing/sequencing block, driven straight from the system clock.

Parameters:
- WIDTH, 4, bit width of count, load_val, max_val.
- RST_VAL, 0, value of count while rst is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- count  output  WIDTH  current counter value, registered.
- en  input  1  count enable; 1 = advance this cycle.
- up  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- clr  input  1  synchronous clear to 0.
- max_val  input  WIDTH  terminal value; tie to all-ones for a plain modulo-2^WIDTH counter.
- tc  output  1  terminal-count pulse, registered.
- wrapped  output  1  sticky flag, set on any wrap event.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): count=RST_VAL, tc=0, wrapped=0. Outputs stay held while rst=0.
- First edge after rst deasserts is a normal active edge.
- Priority per rising edge, highest first: clr > load > en > hold.
  - clr=1: count<=0, tc<=0; wrapped unchanged.
  - load=1: count<=load_val, tc<=0, regardless of en/up.
    - If load_val>max_val, count still takes load_val.
    - The next up-step from any value >= max_val goes to 0 and counts as a wrap.
  - en=1, up=1:
    - count>=max_val: count<=0, tc<=1, wrapped<=1.
    - Otherwise: count<=count+1, tc<=0.
  - en=1, up=0:
    - count==0: count<=max_val, tc<=1, wrapped<=1.
    - Otherwise: count<=count-1, tc<=0.
  - en=0: count holds, tc<=0.
- tc is a one-cycle pulse, high in the cycle after the wrapping edge, i.e. while count shows 0 (up) or max_val (down).
- wrapped clears only on rst.
- Arithmetic is modulo 2^WIDTH; no carry output.
- max_val=0: up-count stays at 0 with tc=1 every enabled cycle; down-count likewise.
- max_val is sampled each edge; changing it mid-count takes effect immediately.
- Reset asserted mid-count forces RST_VAL at once; the counter restarts from RST_VAL on the first edge after release.

Optional Feature:
- Macro: NIBBLE_COUNTER_SAT_EN.
- Defined:
  - Adds input sat (1 bit).
  - When sat=1, counting saturates instead of wrapping: up holds at max_val, down holds at 0.
  - tc=1 on each enabled cycle spent at the limit.
  - wrapped is never set while sat=1.
- Not defined: no sat port; wrap behaviour only.

Test Plan:
- Free-run: rst low 2 cycles, then rst=1, en=1, up=1, max_val=15 for 20 cycles -> count 0,1,...,15,0,1,2,3; tc high exactly while count=0 after the wrap; wrapped=1 from then on.
- Async reset: at count=9, pull rst low between clock edges -> count=0, tc=0, wrapped=0 immediately, before the next edge.
- Down/terminal: max_val=5, up=0 from count=0 -> count 5,4,3,2,1,0,5; tc high while count=5 after each wrap.
- Priority: clr=1, load=1, load_val=7 together -> count=0; next cycle clr=0, load=1 -> count=7; en=0 for 3 cycles -> count stays 7.
- Load above max: max_val=3, load 12, then up with en=1 -> count 12, 0; tc=1 and wrapped=1.
- With NIBBLE_COUNTER_SAT_EN defined, sat=1, max_val=10, up from 8 -> count 8,9,10,10,10; wrapped stays 0.
